// File: rtl/comb_seq_pkg.sv
// comb_seq_pkg: shared encodings and constants for the comb_struct stimulus sequencer
package comb_seq_pkg;
  localparam logic [1:0] MODE_EXH  = 2'd0;
  localparam logic [1:0] MODE_WALK = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int N_EXH  = 16;
  localparam int N_WALK = 4;
  localparam int N_LFSR = 15;
  localparam logic [3:0] LFSR_SEED = 4'b0001;
endpackage

// File: rtl/comb_lfsr4.sv
// comb_lfsr4: combinational next state of the 4-bit maximal-length LFSR
module comb_lfsr4 (
  input  logic [3:0] s,
  output logic [3:0] s_next
);
  assign s_next = {s[2:0], s[3] ^ s[2]};
endmodule

// File: rtl/comb_vector_sequencer.sv
// comb_vector_sequencer: steps {A,B,C,D} through a pattern set with a hold counter and sample strobe
module comb_vector_sequencer
  import comb_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       sample,
  output logic       busy,
  output logic       done,
  output logic [4:0] vec_idx
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_CYCLES > 1 ? HOLD_W'(HOLD_CYCLES - 1) : '0;
  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        vec_q, vec_d, lfsr_next, first_vec, step_vec;
  logic [4:0]        idx_q, idx_d, idx_inc, n_last;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_end, last_vec;

  comb_lfsr4 u_lfsr (.s(vec_q), .s_next(lfsr_next));

  // pattern selection and end-of-hold / end-of-run decode
  always_comb begin
    n_last    = mode_q == MODE_WALK ? 5'(N_WALK - 1) : mode_q == MODE_LFSR ? 5'(N_LFSR - 1) : 5'(N_EXH - 1);
    idx_inc   = idx_q + 5'd1;
    hold_end  = state_q == RUN && !pause && hold_q == HOLD_LAST;
    last_vec  = idx_q == n_last;
    first_vec = mode == MODE_WALK ? 4'b1000 : mode == MODE_LFSR ? LFSR_SEED : 4'b0000;
    step_vec  = mode_q == MODE_WALK ? vec_q >> 1 : mode_q == MODE_LFSR ? lfsr_next : idx_inc[3:0];
  end

  // IDLE -> RUN -> DONE -> IDLE; vector and index are cleared on entry to DONE
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      mode_d  = mode;
      vec_d   = first_vec;
      idx_d   = '0;
      hold_d  = '0;
    end else if (state_q == RUN && !pause) begin
      if (hold_end) begin
        state_d = last_vec ? DONE : RUN;
        vec_d   = last_vec ? 4'b0000 : step_vec;
        idx_d   = last_vec ? 5'd0 : idx_inc;
        hold_d  = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_EXH;
      vec_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign {A, B, C, D} = vec_q;
  assign vec_idx      = idx_q;
  assign busy         = state_q == RUN;
  assign done         = state_q == DONE;
  assign sample       = hold_end;
endmodule

// File: tb/tb_comb_vector_sequencer.sv
// tb_comb_vector_sequencer: scoreboard bench for the vector sequencer
module tb_comb_vector_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, start1 = 1'b0, pause1 = 1'b0;
  logic [1:0] mode = 2'd0, mode1 = 2'd0;
  logic       A, B, C, D, sample, busy, done;
  logic       A1, B1, C1, D1, sample1, busy1, done1;
  logic [4:0] vec_idx, vec_idx1;
  int         checks = 0, errors = 0, nsamp = 0, nsamp1 = 0;
  logic [8:0] sbq[$], sbq1[$];
  logic [3:0] seen[$];

  always #5 clk = ~clk;

  comb_vector_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pause(pause),
    .A(A), .B(B), .C(C), .D(D), .sample(sample), .busy(busy), .done(done), .vec_idx(vec_idx)
  );

  comb_vector_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .pause(pause1),
    .A(A1), .B(B1), .C(C1), .D(D1), .sample(sample1), .busy(busy1), .done(done1), .vec_idx(vec_idx1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int m);
    return m == 1 ? 4 : m == 2 ? 15 : 16;
  endfunction

  function automatic logic [3:0] exp_vec(input int m, input int i);
    logic [3:0] s;
    if (m == 1) begin
      s = 4'b1000;
      return s >> i;
    end
    if (m == 2) begin
      s = 4'b0001;
      repeat (i) s = {s[2:0], s[3] ^ s[2]};
      return s;
    end
    return 4'(i);
  endfunction

  task automatic load(input int m, input bit which);
    for (int i = 0; i < n_of(m); i++)
      if (which) sbq1.push_back({exp_vec(m, i), 5'(i)});
      else       sbq.push_back({exp_vec(m, i), 5'(i)});
  endtask

  always @(negedge clk) if (sample) begin
    logic [8:0] e;
    nsamp++;
    seen.push_back({A, B, C, D});
    check("sb_avail", 32'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("sample_vec", {A, B, C, D, vec_idx}, e);
    end
  end

  always @(negedge clk) if (sample1) begin
    logic [8:0] e;
    nsamp1++;
    check("sb1_avail", 32'(sbq1.size() != 0), 1);
    if (sbq1.size() != 0) begin
      e = sbq1.pop_front();
      check("sample1_vec", {A1, B1, C1, D1, vec_idx1}, e);
    end
  end

  task automatic run(input logic [1:0] m, input bit pz, input int exp_len);
    int cycles, n0;
    bit paused;
    logic [8:0] snap;
    load(m, 0);
    seen.delete();
    n0 = nsamp;
    paused = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = m ^ 2'b01;
    cycles = 1;
    check("busy_rise", busy, 1);
    while (!done && cycles < 400) begin
      if (pz && !paused && vec_idx == 5'd5) begin
        pause = 1'b1;
        snap  = {A, B, C, D, vec_idx};
        repeat (7) begin
          @(negedge clk);
          cycles++;
          check("pause_sample", sample, 0);
          check("pause_frozen", {A, B, C, D, vec_idx}, snap);
          check("pause_busy", busy, 1);
        end
        pause  = 1'b0;
        paused = 1;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    check("run_len", cycles, exp_len);
    check("done_outs", {A, B, C, D, vec_idx, busy}, 0);
    check("n_samples", nsamp - n0, n_of(m));
    check("sb_drained", sbq.size(), 0);
    @(negedge clk);
    check("idle_after", {busy, done, sample}, 0);
    sbq.delete();
  endtask

  initial begin
    logic [15:0] mask;
    int dcount;
    repeat (2) @(negedge clk);
    check("reset_outs", {A, B, C, D, busy, sample, done, vec_idx}, 0);
    check("reset_outs1", {A1, B1, C1, D1, busy1, sample1, done1, vec_idx1}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_run", busy, 0);

    run(2'd0, 0, 161);
    run(2'd1, 0, 41);
    run(2'd2, 0, 151);
    mask = '0;
    foreach (seen[i]) mask[seen[i]] = 1'b1;
    check("lfsr_count", seen.size(), 15);
    check("lfsr_distinct_nonzero", mask, 16'hFFFE);
    check("lfsr_third", seen.size() > 2 ? seen[2] : 4'hF, 4'b0100);
    check("lfsr_last", seen.size() > 14 ? seen[14] : 4'hF, 4'b1000);
    run(2'd0, 1, 168);

    load(0, 0);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    check("pre_rst", {busy, vec_idx, A, B, C, D}, {1'b1, 5'd2, 4'd2});
    rst = 1'b1;
    #1;
    check("rst_async", {A, B, C, D, busy, sample, done, vec_idx}, 0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no_done_after_rst", dcount, 0);

    load(3, 1);
    load(3, 1);
    @(negedge clk);
    start1 = 1'b1;
    mode1  = 2'd3;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c == 5)  mode1 = 2'd1;
      if (c == 10) mode1 = 2'd3;
      if (c == 25) mode1 = 2'd2;
      if (c == 1)  check("b2b_first", {busy1, sample1, A1, B1, C1, D1}, 6'b110000);
      if (c == 17 || c == 35) check("b2b_done", {done1, busy1}, 2'b10);
      if (c == 18) check("b2b_idle", {busy1, done1, sample1}, 0);
      if (c == 19) check("b2b_restart", {busy1, sample1, A1, B1, C1, D1, vec_idx1}, {6'b110000, 5'd0});
      if (c == 35) start1 = 1'b0;
      if (c == 36) check("b2b_stop", {busy1, done1}, 0);
    end
    check("b2b_samples", nsamp1, 32);
    check("b2b_drained", sbq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
